// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-requester fixed-priority arbiter for the single-port system RAM
module mem_arbiter #(
  parameter int AW = 18,
  parameter int DW = 8
) (
  input  logic          F14Mx2,
  input  logic          reset,
  input  logic          vdc_req,
  input  logic          vdc_we,
  input  logic [AW-1:0] vdc_addr,
  input  logic [DW-1:0] vdc_wdata,
  output logic          vdc_ready,
  output logic          vdc_ack,
  output logic [DW-1:0] vdc_rdata,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [DW-1:0] dl_data,
  output logic          dl_ready,
  input  logic          er_wr,
  input  logic [AW-1:0] er_addr,
  input  logic [DW-1:0] er_data,
  output logic          er_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q,
  output logic          busy,
  output logic          ovf
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;

  localparam logic [1:0] OWN_VDC = 2'd0;
  localparam logic [1:0] OWN_DL  = 2'd1;
  localparam logic [1:0] OWN_ER  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    owner;

  logic          vdc_full;
  logic          vdc_we_q;
  logic [AW-1:0] vdc_addr_q;
  logic [DW-1:0] vdc_data_q;

  logic          dl_full;
  logic [AW-1:0] dl_addr_q;
  logic [DW-1:0] dl_data_q;

  logic          er_full;
  logic [AW-1:0] er_addr_q;
  logic [DW-1:0] er_data_q;

  // Slot is released at the end of its ISSUE cycle; a strobe that cycle still sees full=1.
  logic          clr_vdc;
  logic          clr_dl;
  logic          clr_er;

  assign clr_vdc = (state == ST_ISSUE) && (owner == OWN_VDC);
  assign clr_dl  = (state == ST_ISSUE) && (owner == OWN_DL);
  assign clr_er  = (state == ST_ISSUE) && (owner == OWN_ER);

  assign vdc_ready = ~vdc_full;
  assign dl_ready  = ~dl_full;
  assign er_ready  = ~er_full;
  assign busy      = vdc_full | dl_full | er_full | (state != ST_IDLE);

  // VTL holding slot: capture a strobe only when empty
  always_ff @(posedge F14Mx2) begin
    if (reset) begin
      vdc_full   <= 1'b0;
      vdc_we_q   <= 1'b0;
      vdc_addr_q <= '0;
      vdc_data_q <= '0;
    end else begin
      if (clr_vdc) vdc_full <= 1'b0;
      if (vdc_req && !vdc_full) begin
        vdc_full   <= 1'b1;
        vdc_we_q   <= vdc_we;
        vdc_addr_q <= vdc_addr;
        vdc_data_q <= vdc_wdata;
      end
    end
  end

  // Downloader holding slot (write-only)
  always_ff @(posedge F14Mx2) begin
    if (reset) begin
      dl_full   <= 1'b0;
      dl_addr_q <= '0;
      dl_data_q <= '0;
    end else begin
      if (clr_dl) dl_full <= 1'b0;
      if (dl_wr && !dl_full) begin
        dl_full   <= 1'b1;
        dl_addr_q <= dl_addr;
        dl_data_q <= dl_data;
      end
    end
  end

  // Eraser holding slot (write-only)
  always_ff @(posedge F14Mx2) begin
    if (reset) begin
      er_full   <= 1'b0;
      er_addr_q <= '0;
      er_data_q <= '0;
    end else begin
      if (clr_er) er_full <= 1'b0;
      if (er_wr && !er_full) begin
        er_full   <= 1'b1;
        er_addr_q <= er_addr;
        er_data_q <= er_data;
      end
    end
  end

  // Sticky overflow: any strobe that finds its slot occupied is lost
  always_ff @(posedge F14Mx2) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if ((vdc_req && vdc_full) || (dl_wr && dl_full) || (er_wr && er_full)) begin
      ovf <= 1'b1;
    end
  end

  // Access sequencer: one RAM access at a time, priority vdc > dl > er
  always_ff @(posedge F14Mx2) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= OWN_VDC;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_wren  <= 1'b0;
      vdc_ack   <= 1'b0;
      vdc_rdata <= '0;
    end else begin
      vdc_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (vdc_full) begin
            mem_addr <= vdc_addr_q;
            mem_din  <= vdc_data_q;
            mem_wren <= vdc_we_q;
            owner    <= OWN_VDC;
            state    <= ST_ISSUE;
          end else if (dl_full) begin
            mem_addr <= dl_addr_q;
            mem_din  <= dl_data_q;
            mem_wren <= 1'b1;
            owner    <= OWN_DL;
            state    <= ST_ISSUE;
          end else if (er_full) begin
            mem_addr <= er_addr_q;
            mem_din  <= er_data_q;
            mem_wren <= 1'b1;
            owner    <= OWN_ER;
            state    <= ST_ISSUE;
          end else begin
            mem_wren <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // mem_wren still holds the owner's we bit, so it tells write from read here
          mem_wren <= 1'b0;
          if (mem_wren) begin
            if (owner == OWN_VDC) vdc_ack <= 1'b1;
            state <= ST_IDLE;
          end else begin
            state <= ST_READ;
          end
        end
        ST_READ: begin
          vdc_rdata <= mem_q;
          vdc_ack   <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          mem_wren <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        vdc_req, vdc_we;
  logic [17:0] vdc_addr;
  logic [7:0]  vdc_wdata;
  logic        vdc_ready, vdc_ack;
  logic [7:0]  vdc_rdata;
  logic        dl_wr;
  logic [17:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_ready;
  logic        er_wr;
  logic [17:0] er_addr;
  logic [7:0]  er_data;
  logic        er_ready;
  logic [17:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_wren;
  logic [7:0]  mem_q;
  logic        busy, ovf;

  mem_arbiter #(.AW(18), .DW(8)) dut (
    .F14Mx2(clk), .reset(reset),
    .vdc_req(vdc_req), .vdc_we(vdc_we), .vdc_addr(vdc_addr), .vdc_wdata(vdc_wdata),
    .vdc_ready(vdc_ready), .vdc_ack(vdc_ack), .vdc_rdata(vdc_rdata),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ready(dl_ready),
    .er_wr(er_wr), .er_addr(er_addr), .er_data(er_data), .er_ready(er_ready),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wren(mem_wren), .mem_q(mem_q),
    .busy(busy), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read, one cycle after address
  logic [7:0] ram [0:262143];
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_din;
    mem_q <= ram[mem_addr];
  end

  typedef struct {int cyc; logic [17:0] addr; logic [7:0] data;} wr_t;
  typedef struct {int cyc; logic rd; logic [7:0] data;} ack_t;
  wr_t  wq[$];
  ack_t aq[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every RAM write and every ack must match the head of its queue
  always @(negedge clk) begin
    if (mem_wren === 1'b1) begin
      n_vec++;
      if (wq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write addr=%h din=%h cyc=%0d", mem_addr, mem_din, cyc);
      end else begin
        wr_t e;
        e = wq.pop_front();
        if (e.cyc != cyc || e.addr !== mem_addr || e.data !== mem_din) begin
          n_err++;
          $display("FAIL ram_write actual cyc=%0d addr=%h din=%h expected cyc=%0d addr=%h din=%h",
                   cyc, mem_addr, mem_din, e.cyc, e.addr, e.data);
        end
      end
    end
    if (vdc_ack === 1'b1) begin
      n_vec++;
      if (aq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ack rdata=%h cyc=%0d", vdc_rdata, cyc);
      end else begin
        ack_t a;
        a = aq.pop_front();
        if (a.cyc != cyc || (a.rd && vdc_rdata !== a.data)) begin
          n_err++;
          $display("FAIL vdc_ack actual cyc=%0d rdata=%h expected cyc=%0d rdata=%h",
                   cyc, vdc_rdata, a.cyc, a.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    vdc_req = 1'b0;
    dl_wr   = 1'b0;
    er_wr   = 1'b0;
  endtask

  task automatic set_vdc(input logic we, input logic [17:0] a, input logic [7:0] d);
    vdc_req = 1'b1; vdc_we = we; vdc_addr = a; vdc_wdata = d;
  endtask

  task automatic set_dl(input logic [17:0] a, input logic [7:0] d);
    dl_wr = 1'b1; dl_addr = a; dl_data = d;
  endtask

  task automatic set_er(input logic [17:0] a, input logic [7:0] d);
    er_wr = 1'b1; er_addr = a; er_data = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vdc_ready"}, 32'(vdc_ready), 32'd1);
    chk({tag, "_dl_ready"},  32'(dl_ready),  32'd1);
    chk({tag, "_er_ready"},  32'(er_ready),  32'd1);
    chk({tag, "_vdc_ack"},   32'(vdc_ack),   32'd0);
    chk({tag, "_vdc_rdata"}, 32'(vdc_rdata), 32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_din"},   32'(mem_din),   32'd0);
    chk({tag, "_mem_wren"},  32'(mem_wren),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_ovf"},       32'(ovf),       32'd0);
  endtask

  int c0;

  initial begin
    reset = 1'b1;
    vdc_we = 1'b0; vdc_addr = '0; vdc_wdata = '0;
    dl_addr = '0; dl_data = '0; er_addr = '0; er_data = '0;
    clear_strobes();
    repeat (3) step();
    reset = 1'b0;
    repeat (10) step();
    chk_reset_vals("idle");

    // Downloader write: RAM write in c2, slot busy c1-c2
    c0 = cyc;
    set_dl(18'h00123, 8'hA5);
    wq.push_back('{c0 + 2, 18'h00123, 8'hA5});
    step(); clear_strobes();
    chk("dl_ready_c1", 32'(dl_ready), 32'd0);
    chk("busy_c1", 32'(busy), 32'd1);
    step();
    chk("dl_ready_c2", 32'(dl_ready), 32'd0);
    step();
    chk("dl_ready_c3", 32'(dl_ready), 32'd1);
    repeat (3) step();

    // VTL write then read-back five cycles later
    c0 = cyc;
    set_vdc(1'b1, 18'h04000, 8'h3C);
    wq.push_back('{c0 + 2, 18'h04000, 8'h3C});
    aq.push_back('{c0 + 3, 1'b0, 8'h00});
    step(); clear_strobes();
    repeat (4) step();
    set_vdc(1'b0, 18'h04000, 8'h00);
    aq.push_back('{c0 + 9, 1'b1, 8'h3C});
    step(); clear_strobes();
    repeat (6) step();
    chk("rdata_hold", 32'(vdc_rdata), 32'h3C);

    // All three together: vdc read c2/ack c4, dl c5, er c7
    c0 = cyc;
    set_vdc(1'b0, 18'h00123, 8'h00);
    set_dl(18'h00010, 8'h11);
    set_er(18'h00020, 8'h22);
    aq.push_back('{c0 + 4, 1'b1, 8'hA5});
    wq.push_back('{c0 + 5, 18'h00010, 8'h11});
    wq.push_back('{c0 + 7, 18'h00020, 8'h22});
    step(); clear_strobes();
    repeat (9) step();
    chk("simul_ovf", 32'(ovf), 32'd0);
    chk("simul_busy", 32'(busy), 32'd0);

    // Back-to-back downloader strobes: second dropped, ovf sticky
    c0 = cyc;
    set_dl(18'h00030, 8'h33);
    wq.push_back('{c0 + 2, 18'h00030, 8'h33});
    step();
    set_dl(18'h00031, 8'h44);
    step(); clear_strobes();
    chk("ovf_set", 32'(ovf), 32'd1);
    repeat (5) step();
    chk("ovf_sticky", 32'(ovf), 32'd1);
    chk("ovf_dl_ready", 32'(dl_ready), 32'd1);

    // Reset during eraser ISSUE: write lands, then everything clears
    c0 = cyc;
    set_er(18'h3FFFF, 8'h5A);
    wq.push_back('{c0 + 2, 18'h3FFFF, 8'h5A});
    step(); clear_strobes();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals("rst_issue");
    chk("rst_issue_ram", 32'(ram[18'h3FFFF]), 32'h5A);
    repeat (3) step();

    // Normal read to load vdc_rdata, then reset during a READ: no ack, rdata back to 0
    c0 = cyc;
    set_vdc(1'b0, 18'h00123, 8'h00);
    aq.push_back('{c0 + 4, 1'b1, 8'hA5});
    step(); clear_strobes();
    repeat (5) step();
    chk("pre_rst_rdata", 32'(vdc_rdata), 32'hA5);
    set_vdc(1'b0, 18'h04000, 8'h00);
    step(); clear_strobes();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_read_ack", 32'(vdc_ack), 32'd0);
    chk("rst_read_rdata", 32'(vdc_rdata), 32'd0);
    chk("rst_read_busy", 32'(busy), 32'd0);
    repeat (10) step();

    chk("writes_drained", 32'(wq.size()), 32'd0);
    chk("acks_drained", 32'(aq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
